// File: rtl/mem_sequencer.sv
// Byte-serial load/store sequencer: moves 1, 2 or 4 big-endian bytes between a request port and a byte memory.
// Optional build macro MEMSEQ_ALIGN_CHECK_EN rejects misaligned word/long requests.
module mem_sequencer #(
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  op_write_i,
  input  logic [1:0]            size_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [31:0]           rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [7:0]            mem_data_in_o,
  input  logic [7:0]            mem_data_out_i,
  output logic                  mem_write_o,
  input  logic                  mem_ready_i
);

  // state   | meaning
  // IDLE    | waiting for req
  // RADDR   | present read address of current byte
  // RWAIT   | read latency countdown
  // RCAP    | capture read byte once mem_ready is high
  // WSETUP  | load write address/data of current byte
  // WSTROBE | hold mem_write until mem_ready is high
  // FIN     | done pulse (rejected requests spend one extra cycle here first)
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RADDR   = 3'd1,
    RWAIT   = 3'd2,
    RCAP    = 3'd3,
    WSETUP  = 3'd4,
    WSTROBE = 3'd5,
    FIN     = 3'd6
  } state_e;

  localparam logic [2:0] WAIT_INIT = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            idx_q;
  logic [1:0]            last_q;
  logic [2:0]            wait_q;
  logic [31:0]           wbuf_q;
  logic [31:0]           acc_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [31:0]           rdata_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            din_q;
  logic                  mw_q;

  logic                  reject_d;
  logic [1:0]            last_d;
  logic [31:0]           wbuf_d;
  logic [ADDR_WIDTH-1:0] byte_addr_d;

  always_comb begin
    reject_d = (size_i == 2'd3);
`ifdef MEMSEQ_ALIGN_CHECK_EN
    if (size_i == 2'd1 && addr_i[0]) reject_d = 1'b1;
    if (size_i == 2'd2 && addr_i[1:0] != 2'b00) reject_d = 1'b1;
`endif
  end

  // Write data is left-justified so the most significant used byte goes out first.
  always_comb begin
    case (size_i)
      2'd0:    begin last_d = 2'd0; wbuf_d = {wdata_i[7:0], 24'h0};  end
      2'd1:    begin last_d = 2'd1; wbuf_d = {wdata_i[15:0], 16'h0}; end
      default: begin last_d = 2'd3; wbuf_d = wdata_i;                end
    endcase
  end

  assign byte_addr_d = addr_q + ADDR_WIDTH'(idx_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      wait_q  <= 3'd0;
      wbuf_q  <= 32'h0;
      acc_q   <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= 32'h0;
      raddr_q <= '0;
      waddr_q <= '0;
      din_q   <= 8'h0;
      mw_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q <= addr_i;
            idx_q  <= 2'd0;
            last_q <= last_d;
            wbuf_q <= wbuf_d;
            acc_q  <= 32'h0;
            busy_q <= 1'b1;
            if (reject_d)        state_q <= FIN;
            else if (op_write_i) state_q <= WSETUP;
            else                 state_q <= RADDR;
          end
        end
        RADDR: begin
          raddr_q <= byte_addr_d;
          if (READ_LATENCY > 1) begin
            wait_q  <= WAIT_INIT;
            state_q <= RWAIT;
          end else begin
            state_q <= RCAP;
          end
        end
        RWAIT: begin
          if (wait_q == 3'd0) state_q <= RCAP;
          else                wait_q  <= wait_q - 3'd1;
        end
        RCAP: begin
          if (mem_ready_i) begin
            acc_q <= {acc_q[23:0], mem_data_out_i};
            if (idx_q == last_q) begin
              rdata_q <= {acc_q[23:0], mem_data_out_i};
              done_q  <= 1'b1;
              error_q <= 1'b0;
              state_q <= FIN;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= RADDR;
            end
          end
        end
        WSETUP: begin
          waddr_q <= byte_addr_d;
          din_q   <= wbuf_q[31:24];
          wbuf_q  <= {wbuf_q[23:0], 8'h0};
          mw_q    <= 1'b1;
          state_q <= WSTROBE;
        end
        WSTROBE: begin
          if (mem_ready_i) begin
            mw_q <= 1'b0;
            if (idx_q == last_q) begin
              done_q  <= 1'b1;
              error_q <= 1'b0;
              state_q <= FIN;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= WSETUP;
            end
          end
        end
        FIN: begin
          // Accesses arrive with done already set; a rejected request raises it here.
          if (!done_q) begin
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign rdata_o       = rdata_q;
  assign mem_raddr_o   = raddr_q;
  assign mem_waddr_o   = waddr_q;
  assign mem_data_in_o = din_q;
  assign mem_write_o   = mw_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a byte memory model and a done-time scoreboard.
module tb_mem_sequencer;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          op_write = 1'b0;
  logic [1:0]    size = 2'd0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = 32'h0;
  logic          mem_ready = 1'b1;
  logic          busy, done, error, mem_write;
  logic [31:0]   rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [7:0]    mem_data_in, mem_data_out;

  mem_sequencer #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_i(req), .op_write_i(op_write), .size_i(size),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done), .error_o(error),
    .rdata_o(rdata), .mem_raddr_o(mem_raddr), .mem_waddr_o(mem_waddr),
    .mem_data_in_o(mem_data_in), .mem_data_out_i(mem_data_out),
    .mem_write_o(mem_write), .mem_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:511];
  assign mem_data_out = mem[mem_raddr];

  // Memory-side observer: accepted writes, strobe cycles, done pulses, strobe stability.
  logic [AW-1:0] wr_addr [0:31];
  logic [7:0]    wr_data [0:31];
  int            wr_cnt = 0;
  int            mw_cyc = 0;
  int            done_cnt = 0;
  int            stab_err = 0;
  logic          prev_mw = 1'b0;
  logic [AW-1:0] prev_waddr = '0;
  logic [7:0]    prev_din = 8'h0;

  always @(posedge clk) begin
    if (mem_write && mem_ready) begin
      wr_addr[wr_cnt[4:0]] <= mem_waddr;
      wr_data[wr_cnt[4:0]] <= mem_data_in;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_write) mw_cyc <= mw_cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_write && prev_mw && (mem_waddr !== prev_waddr || mem_data_in !== prev_din))
      stab_err <= stab_err + 1;
    prev_mw    <= mem_write;
    prev_waddr <= mem_waddr;
    prev_din   <= mem_data_in;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rd;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] model_rdata = 32'h0;

  // Issues one request; done is expected exp_cyc edges after the req edge.
  // mem_ready is held low for rs_len cycles starting after edge rs_start.
  task automatic run(input string tag, input logic op, input logic [1:0] sz,
                     input logic [AW-1:0] a, input logic [31:0] wd, input int exp_cyc,
                     input logic exp_err, input logic [31:0] exp_rd,
                     input int rs_start, input int rs_len);
    exp_t e;
    int   cyc;
    bit   got;
    e.cyc = exp_cyc;
    e.err = exp_err;
    e.rd  = exp_rd;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b1; op_write = op; size = sz; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; size = 2'(sz + 2'd1); addr = AW'($urandom); wdata = $urandom;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
      if (rs_len > 0 && cyc == rs_start) mem_ready = 1'b0;
      if (rs_len > 0 && cyc == rs_start + rs_len) mem_ready = 1'b1;
      if (!op && rs_len > 0 && cyc == rs_start + 1) check({tag, "_raddr_hold"}, 32'(mem_raddr), 32'(a));
      req = (cyc == 1 && exp_cyc > 2 && !got);
    end
    req = 1'b0;
    mem_ready = 1'b1;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    e = sb.pop_front();
    check({tag, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
    check({tag, "_error"}, 32'(error), 32'(e.err));
    check({tag, "_rdata"}, rdata, e.rd);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  int wr0, mw0, d0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h0;
    mem[9'h010] = 8'h12; mem[9'h011] = 8'h34; mem[9'h012] = 8'h56; mem[9'h013] = 8'h78;
    mem[9'h021] = 8'hA1; mem[9'h022] = 8'hB2; mem[9'h023] = 8'hC3; mem[9'h024] = 8'hD4;
    mem[9'h1FF] = 8'h5A; mem[9'h000] = 8'h99;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_raddr", 32'(mem_raddr), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_data_in", 32'(mem_data_in), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    model_rdata = 32'h12345678;
    run("long_load", 1'b0, 2'd2, 9'h010, 32'h0, 8, 1'b0, model_rdata, 0, 0);
    model_rdata = 32'h00000078;
    run("byte_load", 1'b0, 2'd0, 9'h013, 32'h0, 2, 1'b0, model_rdata, 0, 0);
    model_rdata = 32'h00005A99;
    run("word_load_wrap", 1'b0, 2'd1, 9'h1FF, 32'h0, 4, 1'b0, model_rdata, 0, 0);
    model_rdata = 32'h00000056;
    run("load_stall", 1'b0, 2'd0, 9'h012, 32'h0, 4, 1'b0, model_rdata, 1, 2);

    wr0 = wr_cnt; mw0 = mw_cyc;
    run("word_store_wrap", 1'b1, 2'd1, 9'h1FF, 32'h1234BEEF, 4, 1'b0, model_rdata, 0, 0);
    check("wst_writes", 32'(wr_cnt - wr0), 32'd2);
    check("wst_mw_cycles", 32'(mw_cyc - mw0), 32'd2);
    check("wst_addr0", 32'(wr_addr[(wr0) & 31]), 32'h1FF);
    check("wst_data0", 32'(wr_data[(wr0) & 31]), 32'hBE);
    check("wst_addr1", 32'(wr_addr[(wr0 + 1) & 31]), 32'h000);
    check("wst_data1", 32'(wr_data[(wr0 + 1) & 31]), 32'hEF);

    wr0 = wr_cnt; mw0 = mw_cyc;
    run("byte_store_stall", 1'b1, 2'd0, 9'h040, 32'h123456C3, 5, 1'b0, model_rdata, 1, 3);
    check("bst_writes", 32'(wr_cnt - wr0), 32'd1);
    check("bst_mw_cycles", 32'(mw_cyc - mw0), 32'd4);
    check("bst_addr", 32'(wr_addr[wr0 & 31]), 32'h040);
    check("bst_data", 32'(wr_data[wr0 & 31]), 32'hC3);

    wr0 = wr_cnt; mw0 = mw_cyc;
    run("long_store", 1'b1, 2'd2, 9'h050, 32'hCAFEF00D, 8, 1'b0, model_rdata, 0, 0);
    check("lst_writes", 32'(wr_cnt - wr0), 32'd4);
    check("lst_mw_cycles", 32'(mw_cyc - mw0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'hCAFEF00D;
      check($sformatf("lst_addr%0d", i), 32'(wr_addr[(wr0 + i) & 31]), 32'h050 + 32'(i));
      check($sformatf("lst_data%0d", i), 32'(wr_data[(wr0 + i) & 31]), 32'(w[8*(3-i) +: 8]));
    end

    wr0 = wr_cnt; mw0 = mw_cyc;
    run("illegal_size", 1'b0, 2'd3, 9'h010, 32'h0, 1, 1'b1, model_rdata, 0, 0);
    check("ill_writes", 32'(wr_cnt - wr0), 32'd0);
    check("ill_mw_cycles", 32'(mw_cyc - mw0), 32'd0);

`ifdef MEMSEQ_ALIGN_CHECK_EN
    run("unaligned_long", 1'b0, 2'd2, 9'h021, 32'h0, 1, 1'b1, model_rdata, 0, 0);
`else
    model_rdata = 32'hA1B2C3D4;
    run("unaligned_long", 1'b0, 2'd2, 9'h021, 32'h0, 8, 1'b0, model_rdata, 0, 0);
`endif

    // Reset mid-store while the strobe is held by a stalled memory.
    wr0 = wr_cnt; d0 = done_cnt;
    @(negedge clk);
    req = 1'b1; op_write = 1'b1; size = 2'd2; addr = 9'h060; wdata = 32'h11223344;
    @(posedge clk); #1;
    req = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_mw_before", 32'(mem_write), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_mw_after", 32'(mem_write), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
    model_rdata = 32'h00000012;
    run("after_abort", 1'b0, 2'd0, 9'h010, 32'h0, 2, 1'b0, model_rdata, 0, 0);

    check("strobe_stable", 32'(stab_err), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, sets the width of the byte address for the request and memory ports.
REQ-002 Parameter READ_LATENCY, default 1, legal range 1..7, sets the number of cycles from mem_raddr valid to mem_data_out sampled.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  1  request strobe; sampled only in IDLE.
REQ-006 op_write  in  1  1 = store, 0 = load; latched with req.
REQ-007 size  in  2  0 = byte, 1 = word (2 B), 2 = long (4 B), 3 = illegal; latched with req.
REQ-008 addr  in  ADDR_WIDTH  start byte address; latched with req.
REQ-009 wdata  in  32  store data; latched with req; the low 8*n bits are used.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 error  out  1  valid with done; 1 = access rejected.
REQ-013 rdata  out  32  load result, zero-extended; valid from done until the next accepted load.
REQ-014 mem_raddr  out  ADDR_WIDTH  memory read address.
REQ-015 mem_waddr  out  ADDR_WIDTH  memory write address.
REQ-016 mem_data_in  out  8  byte to memory.
REQ-017 mem_data_out  in  8  byte from memory.
REQ-018 mem_write  out  1  write strobe.
REQ-019 mem_ready  in  1  memory ready; qualifies both read capture and write strobes.

Function
REQ-020 States SHALL be IDLE, RADDR, RWAIT, RCAP, WSETUP, WSTROBE and FIN; FIN drives done for one cycle and then returns to IDLE.
REQ-021 In IDLE, req=1 SHALL latch op_write, size, addr and wdata, and clear the byte index; req in any other state SHALL be ignored.
REQ-022 Multi-byte transfers SHALL be big-endian: byte i goes to address addr+i and carries bits [8*(n-1-i)+7 : 8*(n-1-i)].
REQ-023 Address arithmetic SHALL be modulo 2^ADDR_WIDTH: addr+i wraps to 0 with no error.
REQ-024 Load: each byte SHALL present mem_raddr, wait READ_LATENCY cycles, then capture mem_data_out only when mem_ready=1; otherwise RCAP holds with mem_raddr unchanged.
REQ-025 With mem_ready held at 1, a load of n bytes SHALL raise done n*(READ_LATENCY+1) cycles after the req edge, with rdata updated on the same edge.
REQ-026 Store: WSETUP SHALL drive mem_waddr and mem_data_in; WSTROBE SHALL assert mem_write until a cycle with mem_ready=1, and that cycle counts as the accepted write.
REQ-027 With mem_ready held at 1, a store of n bytes SHALL raise done 2n cycles after the req edge; mem_write SHALL be high for exactly n cycles.
REQ-028 mem_waddr and mem_data_in SHALL be stable for the whole time mem_write=1.
REQ-029 size=3 SHALL perform no memory access and SHALL raise done together with error=1 one cycle after the req edge.
REQ-030 error SHALL be 0 on every done that completes an access.
REQ-031 rdata SHALL be unchanged by stores and by rejected requests.

Reset
REQ-032 On reset the block SHALL enter IDLE with busy=0, done=0, error=0, mem_write=0, rdata=0, mem_raddr=0, mem_waddr=0 and mem_data_in=0.
REQ-033 Reset during a transfer SHALL abort it at the same edge, produce no done pulse, and deassert mem_write on that edge.

Configuration
REQ-034 Macro MEMSEQ_ALIGN_CHECK_EN: when defined, a word request at an odd addr, or a long request with addr[1:0]!=0, SHALL be rejected exactly as size=3 (no access, done+error one cycle after req).
REQ-035 When MEMSEQ_ALIGN_CHECK_EN is not defined, unaligned requests SHALL execute normally per REQ-022/023.

Verification
REQ-036 Memory 0x10..0x13 = 12 34 56 78, READ_LATENCY=1, long load at 0x10 -> done at cycle 8, rdata=0x12345678, error=0.
REQ-037 Word store 0xBEEF at 0x1FF with ADDR_WIDTH=9 -> writes BE at 0x1FF and EF at 0x000; done at cycle 4.
REQ-038 Byte store with mem_ready held low for 3 cycles during WSTROBE -> mem_write high for 4 cycles, one write, done at cycle 5.
REQ-039 size=3 -> done=1 and error=1 at cycle 1, mem_write never high, rdata unchanged.
REQ-040 Long load at 0x21: with MEMSEQ_ALIGN_CHECK_EN -> error=1 at cycle 1; without it -> bytes 0x21..0x24 returned.
REQ-041 reset asserted at cycle 3 of a long store -> no done, mem_write=0 after that edge, busy=0, next req accepted.
